// File: rtl/iob_eth_mii_loopback_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_eth_mii_loopback_if
// Purpose  : MII/GMII pin bundle between a MAC and the loopback channel model.
//            Signal names are from the channel's point of view
//            (tx_* enter the channel, rx_* leave it).
// Ports    : tx_data_i / tx_en_i / tx_er_i  - MAC transmit side
//            rx_data_o / rx_dv_o / rx_er_o  - MAC receive side
// Modports : master - MAC side (drives tx, observes rx)
//            slave  - channel side (observes tx, drives rx)
// Revision : 1.0 - initial release
// ============================================================================
interface iob_eth_mii_loopback_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_en_i;
  logic              tx_er_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_dv_o;
  logic              rx_er_o;

  modport master (
    output tx_data_i, tx_en_i, tx_er_i,
    input  rx_data_o, rx_dv_o, rx_er_o
  );

  modport slave (
    input  tx_data_i, tx_en_i, tx_er_i,
    output rx_data_o, rx_dv_o, rx_er_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_eth_mii_loopback.sv
`default_nettype none
// ============================================================================
// Module   : iob_eth_mii_loopback
// Purpose  : Cycle-accurate MII/GMII loopback channel for MAC simulation.
//            DELAY-stage pipeline of {dv, er, data}, frame tracking FSM,
//            frame/beat statistics and optional one-shot beat corruption.
// Params   : DATA_W (4=MII, 8=GMII), DELAY (1..64 cycles), CNT_W (counters)
// Ports    : clk_i, arst_n_i (async, active-low), en_i (sampled in IDLE)
//            mii            - tx/rx pin bundle (slave modport)
//            corrupt_arm_i  - pulse: latch corrupt_idx_i/corrupt_mask_i, arm
//            armed_o        - corruption pending
//            frame_cnt_o    - completed frames (wrapping)
//            last_len_o     - beats in last completed frame (saturating)
//            busy_o         - high while in FRAME or GAP
// Config   : `define IOB_ETH_LOOPBACK_ERR_INJ_EN to build the corruption
//            logic; otherwise corrupt_* are ignored and armed_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module iob_eth_mii_loopback #(
  parameter int DATA_W = 4,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 16
) (
  input  wire logic              clk_i,
  input  wire logic              arst_n_i,
  input  wire logic              en_i,
  iob_eth_mii_loopback_if.slave  mii,
  input  wire logic              corrupt_arm_i,
  input  wire logic [CNT_W-1:0]  corrupt_idx_i,
  input  wire logic [DATA_W-1:0] corrupt_mask_i,
  output logic                   armed_o,
  output logic [CNT_W-1:0]       frame_cnt_o,
  output logic [CNT_W-1:0]       last_len_o,
  output logic                   busy_o
);

  localparam int STG_W = DATA_W + 2;
  localparam int GAP_W = $clog2(DELAY) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              loop_en_q, loop_en_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  last_len_q, last_len_d;
  logic              busy_q, busy_d;
  logic [STG_W-1:0]  pipe_q [DELAY];
  logic [STG_W-1:0]  stage0;
  logic [DATA_W-1:0] xor_mask;

`ifdef IOB_ETH_LOOPBACK_ERR_INJ_EN
  logic              armed_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] mask_q;
  logic [CNT_W-1:0]  beat_idx;
  logic              match;

  // Index of the beat currently on tx: in FRAME it equals the beats seen so
  // far; a beat arriving outside FRAME starts a frame and is index 0.
  assign beat_idx = (state_q == S_FRAME) ? beat_cnt_q : '0;
  // Restarts out of GAP are not candidates for corruption.
  assign match    = armed_q && loop_en_q && mii.tx_en_i &&
                    (state_q != S_GAP) && (beat_idx == idx_q);
  assign xor_mask = match ? mask_q : '0;

  // A new arm pulse wins over the clear from a simultaneous match; the
  // current beat has already used the old index/mask combinationally.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      armed_q <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
    end else if (corrupt_arm_i) begin
      armed_q <= 1'b1;
      idx_q   <= corrupt_idx_i;
      mask_q  <= corrupt_mask_i;
    end else if (match) begin
      armed_q <= 1'b0;
    end
  end

  assign armed_o = armed_q;
`else
  logic unused_corrupt;
  assign unused_corrupt = ^{corrupt_arm_i, corrupt_idx_i, corrupt_mask_i};
  assign xor_mask       = '0;
  assign armed_o        = 1'b0;
`endif

  // Channel input is forced idle while the loop is disabled.
  assign stage0 = loop_en_q ? {mii.tx_en_i, mii.tx_er_i, mii.tx_data_i ^ xor_mask}
                            : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign mii.rx_dv_o   = pipe_q[DELAY-1][STG_W-1];
  assign mii.rx_er_o   = pipe_q[DELAY-1][STG_W-2];
  assign mii.rx_data_o = pipe_q[DELAY-1][DATA_W-1:0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      loop_en_q   <= 1'b0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      last_len_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      loop_en_q   <= loop_en_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      last_len_q  <= last_len_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    last_len_d  = last_len_q;
    // The enable only changes between frames so a frame is never truncated.
    loop_en_d   = (state_q == S_IDLE) ? en_i : loop_en_q;

    case (state_q)
      S_IDLE: begin
        if (loop_en_q && mii.tx_en_i) begin
          state_d    = S_FRAME;
          beat_cnt_d = CNT_W'(1);
        end
      end
      S_FRAME: begin
        if (mii.tx_en_i) begin
          if (!(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          state_d     = S_GAP;
          gap_cnt_d   = '0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          last_len_d  = beat_cnt_q;
        end
      end
      S_GAP: begin
        // GAP holds for DELAY cycles so the frame tail drains before IDLE.
        if (mii.tx_en_i) begin
          state_d    = S_FRAME;
          beat_cnt_d = CNT_W'(1);
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign frame_cnt_o = frame_cnt_q;
  assign last_len_o  = last_len_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_mii_loopback.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_eth_mii_loopback
// Purpose  : Directed self-checking bench for iob_eth_mii_loopback
//            (DATA_W=4, DELAY=3, CNT_W=16). Expected corruption values follow
//            whether IOB_ETH_LOOPBACK_ERR_INJ_EN is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_eth_mii_loopback;

`ifdef IOB_ETH_LOOPBACK_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic        c_arm = 1'b0;
  logic [15:0] c_idx = '0;
  logic [3:0]  c_mask = '0;
  logic        armed;
  logic [15:0] frame_cnt;
  logic [15:0] last_len;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Receive-side log, filled by the monitor while cap_on is set.
  bit         cap_on = 1'b0;
  int         first_dv = -1;
  int         ndv = 0;
  logic [63:0] patmask = '0;
  logic [63:0] ermask = '0;
  logic [3:0] data_log [$];

  iob_eth_mii_loopback_if #(.DATA_W(4)) mii ();

  iob_eth_mii_loopback #(.DATA_W(4), .DELAY(3), .CNT_W(16)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .en_i           (en),
    .mii            (mii),
    .corrupt_arm_i  (c_arm),
    .corrupt_idx_i  (c_idx),
    .corrupt_mask_i (c_mask),
    .armed_o        (armed),
    .frame_cnt_o    (frame_cnt),
    .last_len_o     (last_len),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (cap_on && mii.rx_dv_o === 1'b1) begin
      if (first_dv < 0) first_dv = cyc;
      if (cyc - first_dv < 64) begin
        patmask[cyc - first_dv] = 1'b1;
        ermask[cyc - first_dv]  = mii.rx_er_o;
      end
      data_log.push_back(mii.rx_data_o);
      ndv++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    cap_on   = 1'b1;
    first_dv = -1;
    ndv      = 0;
    patmask  = '0;
    ermask   = '0;
    data_log.delete();
  endtask

  // Drives n consecutive beats, data = start + i*step.
  task automatic send_frame(input int n, input int start, input int step,
                            input int er_at, input int en_off_at, input bit exp_busy);
    for (int i = 0; i < n; i++) begin
      if (i == en_off_at) en = 1'b0;
      mii.tx_data_i = 4'(start + i * step);
      mii.tx_er_i   = (i == er_at);
      mii.tx_en_i   = 1'b1;
      if (i == 1) chk("busy_in_frame", 64'(busy), 64'(exp_busy));
      tick();
    end
    mii.tx_en_i   = 1'b0;
    mii.tx_er_i   = 1'b0;
    mii.tx_data_i = '0;
  endtask

  task automatic arm(input logic [15:0] idx, input logic [3:0] mask);
    c_arm  = 1'b1;
    c_idx  = idx;
    c_mask = mask;
    tick();
    c_arm  = 1'b0;
  endtask

  task automatic check_data(input string tag, input int n, input int start,
                            input int step, input int hit, input logic [3:0] hmask);
    chk({tag, "_len"}, 64'(data_log.size()), 64'(n));
    for (int i = 0; i < n && i < data_log.size(); i++)
      chk(tag, 64'(data_log[i]), 64'(4'(start + i * step) ^ ((i == hit) ? hmask : 4'h0)));
  endtask

  initial begin
    int t0;
    mii.tx_data_i = '0;
    mii.tx_en_i   = 1'b0;
    mii.tx_er_i   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_rx_dv", 64'(mii.rx_dv_o), 64'(0));
    chk("rst_rx_data", 64'(mii.rx_data_o), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_last_len", 64'(last_len), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_armed", 64'(armed), 64'(0));
    arst_n = 1'b1;
    en     = 1'b1;
    repeat (2) tick();

    // Latency / pass-through: 8 beats 1..8, tx_er on beat 3
    clear_log();
    t0 = cyc;
    send_frame(8, 1, 1, 3, -1, 1'b1);
    repeat (6) tick();
    chk("lat_first_dv", 64'(first_dv), 64'(t0 + 3));
    chk("lat_dv_pattern", patmask, 64'hFF);
    chk("lat_er_pattern", ermask, 64'h8);
    check_data("lat_data", 8, 1, 1, -1, 4'h0);
    chk("lat_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("lat_last_len", 64'(last_len), 64'(8));
    chk("lat_busy_idle", 64'(busy), 64'(0));

    // Corruption: idx 2, mask F on five zero beats
    arm(16'd2, 4'hF);
    chk("cor_armed_set", 64'(armed), 64'(INJ));
    clear_log();
    send_frame(5, 0, 0, -1, -1, 1'b1);
    repeat (6) tick();
    check_data("cor_data", 5, 0, 0, 2, INJ ? 4'hF : 4'h0);
    chk("cor_armed_clr", 64'(armed), 64'(0));
    clear_log();
    send_frame(5, 0, 0, -1, -1, 1'b1);
    repeat (6) tick();
    check_data("cor_second_clean", 5, 0, 0, -1, 4'h0);
    chk("cor_frame_cnt", 64'(frame_cnt), 64'(3));

    // Arm miss carries over: idx 10, 4-beat frame then 12-beat frame
    arm(16'd10, 4'h5);
    clear_log();
    send_frame(4, 0, 0, -1, -1, 1'b1);
    repeat (6) tick();
    check_data("miss_first_clean", 4, 0, 0, -1, 4'h0);
    chk("miss_armed_kept", 64'(armed), 64'(INJ));
    clear_log();
    send_frame(12, 0, 0, -1, -1, 1'b1);
    repeat (6) tick();
    check_data("miss_second", 12, 0, 0, 10, INJ ? 4'h5 : 4'h0);
    chk("miss_armed_clr", 64'(armed), 64'(0));
    chk("miss_last_len", 64'(last_len), 64'(12));

    // Enable boundary: en dropped at beat 3 of a 6-beat frame
    clear_log();
    send_frame(6, 1, 1, -1, 3, 1'b1);
    repeat (6) tick();
    check_data("en_frame_full", 6, 1, 1, -1, 4'h0);
    chk("en_frame_cnt", 64'(frame_cnt), 64'(6));
    clear_log();
    send_frame(4, 7, 1, -1, -1, 1'b0);
    repeat (6) tick();
    chk("en_off_ndv", 64'(ndv), 64'(0));
    chk("en_off_frame_cnt", 64'(frame_cnt), 64'(6));
    chk("en_off_last_len", 64'(last_len), 64'(6));
    en = 1'b1;
    repeat (2) tick();

    // Back-to-back: 4 beats, one idle cycle, 4 beats
    clear_log();
    send_frame(4, 9, 1, -1, -1, 1'b1);
    tick();
    send_frame(4, 13, 1, -1, -1, 1'b1);
    repeat (6) tick();
    chk("b2b_dv_pattern", patmask, 64'h1EF);
    check_data("b2b_data", 8, 9, 1, -1, 4'h0);
    chk("b2b_frame_cnt", 64'(frame_cnt), 64'(8));
    chk("b2b_last_len", 64'(last_len), 64'(4));

    // Reset mid-frame at beat 5
    for (int i = 0; i < 5; i++) begin
      mii.tx_data_i = 4'(i + 1);
      mii.tx_en_i   = 1'b1;
      tick();
    end
    chk("mid_dv_before", 64'(mii.rx_dv_o), 64'(1));
    arst_n = 1'b0;
    #1;
    chk("mid_rst_dv", 64'(mii.rx_dv_o), 64'(0));
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("mid_rst_last_len", 64'(last_len), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    mii.tx_en_i   = 1'b0;
    mii.tx_data_i = '0;
    repeat (2) tick();
    arst_n = 1'b1;
    repeat (2) tick();
    clear_log();
    send_frame(3, 2, 2, -1, -1, 1'b1);
    repeat (6) tick();
    check_data("post_rst_data", 3, 2, 2, -1, 4'h0);
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("post_rst_last_len", 64'(last_len), 64'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_eth_mii_loopback.md
# iob_eth_mii_loopback

Parametrised, cycle-accurate MII/GMII loopback channel model for Ethernet MAC simulation testbenches. It replaces a fixed single-register txd-to-rxd loopback with a channel that has:
- configurable lane width and latency;
- frame tracking (`rx_dv_o` follows `tx_en_i`);
- frame/beat statistics;
- optional one-shot data corruption for MAC error-path testing.

It sits between the MAC's transmit and receive MII pins inside the simulation wrapper, clocked by the Ethernet clock.

## Interface
Parameters:
- `DATA_W`, 4: lane width; 4 = MII, 8 = GMII.
- `DELAY`, 2: channel latency in cycles; legal range 1..64.
- `CNT_W`, 16: width of counters and corruption index.

Ports:
- `clk_i`  in  1  Ethernet clock (MII tx/rx clock).
- `arst_n_i`  in  1  asynchronous active-low reset.
- `en_i`  in  1  loopback enable; sampled only in IDLE.
- `tx_data_i`  in  DATA_W  MAC transmit data.
- `tx_en_i`  in  1  MAC transmit enable.
- `tx_er_i`  in  1  MAC transmit error.
- `rx_data_o`  out  DATA_W  looped receive data.
- `rx_dv_o`  out  1  receive data valid.
- `rx_er_o`  out  1  receive error.
- `corrupt_arm_i`  in  1  one-cycle pulse; latches `corrupt_idx_i` and `corrupt_mask_i`, sets armed.
- `corrupt_idx_i`  in  CNT_W  beat index within frame to corrupt; 0 = first beat.
- `corrupt_mask_i`  in  DATA_W  XOR mask applied to that beat.
- `armed_o`  out  1  corruption pending.
- `frame_cnt_o`  out  CNT_W  completed frames, wraps at 2^CNT_W.
- `last_len_o`  out  CNT_W  beat count of last completed frame, saturates at all-ones.
- `busy_o`  out  1  high in FRAME or GAP.

Clock `clk_i`; reset `arst_n_i` is asynchronous and active-low.

## Operation
Pipeline:
- DELAY-stage shift register of {dv, er, data}.
- Stage 0 input is {`tx_en_i`, `tx_er_i`, `tx_data_i` XOR corruption} when the loop is enabled, otherwise all-zero.
- Outputs are the last stage.

Loop-enabled flag:
- Loads from `en_i` only in IDLE.
- Changing `en_i` during FRAME or GAP takes effect at the next IDLE.

FSM states:
- **IDLE**:
  - `tx_en_i`=1 with loop enabled → FRAME; the beat counter loads 1, and the current beat is index 0.
  - `tx_en_i` is ignored when the loop is disabled.
- **FRAME**:
  - Each cycle with `tx_en_i`=1 increments the beat counter, saturating at all-ones.
  - `tx_en_i`=0 → GAP; `frame_cnt_o` += 1 and `last_len_o` ← beat counter, both on that edge.
- **GAP**:
  - Lasts DELAY cycles (drain time).
  - `tx_en_i`=1 during GAP → FRAME immediately, as in IDLE.
  - Otherwise → IDLE when the gap counter reaches DELAY−1.

Corruption:
- While armed, in IDLE or FRAME, a beat with `tx_en_i`=1 whose index equals the latched index has its data XORed with the latched mask.
- The match clears armed.
- A frame ending without a match leaves armed set for the next frame.
- `tx_er_i` passes unchanged.

Simultaneous arm pulse and match:
- The current beat uses the old index/mask and is corrupted.
- The new values are latched and armed stays set.

## Timing
Reset:
- All pipeline stages, outputs, counters and armed are 0; state is IDLE; loop-enabled flag is 0.
- Reset is asynchronous and takes effect immediately mid-frame; the outputs drop in the same cycle.

Latency:
- `rx_*_o` equals the stage-0 value from exactly DELAY rising edges earlier.
- No bubbles; back-to-back frames are preserved.

`busy_o` is registered:
- Rises the cycle after the first `tx_en_i` beat is sampled.
- Falls on entry to IDLE.

`armed_o`:
- Rises the cycle after `corrupt_arm_i`.
- Falls the cycle after the matching beat.

## Configuration
`IOB_ETH_LOOPBACK_ERR_INJ_EN`:
- **Defined:** corruption logic, latched index/mask and `armed_o` behave as above.
- **Undefined:**
  - the corruption logic is not compiled;
  - `corrupt_*_i` are ignored;
  - `armed_o` is tied 0;
  - data passes bit-exact.

## Test plan
- **Latency/pass-through:** DELAY=3, DATA_W=4; reset, `en_i`=1, send 8 beats 0x1..0x8 with `tx_en_i`=1 → `rx_dv_o` high for exactly 8 cycles starting 3 edges after the first beat, data 0x1..0x8; `frame_cnt_o`=1, `last_len_o`=8.
- **Corruption:** with the macro defined, arm idx=2, mask=0xF, send 0x0 ×5 → `rx_data_o` sequence 0,0,F,0,0; `armed_o` falls after beat 2; a second frame passes uncorrupted.
- **Arm miss carries over:** arm idx=10, send a 4-beat frame then a 12-beat frame → first frame clean and `armed_o` still 1; second frame beat 10 corrupted.
- **Enable boundary:** deassert `en_i` at beat 3 of a 6-beat frame → all 6 beats looped; the next frame produces `rx_dv_o`=0 and `frame_cnt_o` is unchanged.
- **Back-to-back frames:** 4 beats, 1 idle cycle (GAP), 4 beats → `rx_dv_o` pattern 1111 0 1111; `frame_cnt_o`=2.
- **Reset mid-frame:** assert `arst_n_i`=0 at beat 5 → `rx_dv_o`=0, counters 0 immediately; after release, a new 3-beat frame gives `frame_cnt_o`=1, `last_len_o`=3.
